// File: rtl/mxv_pkg.sv
// mxv_pkg: shared constants and types for the matrix-vector frame loader
package mxv_pkg;
  localparam int MAX_N = 8;
  localparam logic [7:0] HDR = 8'hFE;
  localparam logic [7:0] TAIL = 8'hEF;
  typedef enum logic [2:0] {
    CMD_SIZE   = 3'd1,
    CMD_START  = 3'd2,
    CMD_MATRIX = 3'd3,
    CMD_VECTOR = 3'd4
  } cmd_e;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PAYLOAD, S_TAIL} state_e;
  function automatic logic is_cmd(input logic [7:0] b);
    return b >= 8'd1 && b <= 8'd4;
  endfunction
endpackage

// File: rtl/mxv_payload_counter.sv
// mxv_payload_counter: enabled up-counter with clear and last-byte compare
module mxv_payload_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [6:0] limit,
  output logic [6:0] count,
  output logic       last
);
  logic [6:0] count_q, count_d;
  // clear has priority over increment
  always_comb count_d = clr ? 7'd0 : en ? count_q + 7'd1 : count_q;
  // counter register
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= 7'd0;
    else count_q <= count_d;
  assign count = count_q;
  assign last = (count_q + 7'd1) == limit;
endmodule

// File: rtl/mxv_frame_loader.sv
// mxv_frame_loader: parses framed byte stream into multiplier config, vector, matrix pushes and start
module mxv_frame_loader
  import mxv_pkg::*;
#(
  parameter int WORD_LENGTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        mxv_busy,
  output logic [7:0]  matrix_length,
  output logic [63:0] vector,
  output logic [7:0]  fifo_value,
  output logic        fifo_push,
  output logic        start,
  output logic        frame_error
);
  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [3:0]  shadow_len_q, shadow_len_d;
  logic [63:0] shadow_vec_q, shadow_vec_d;
  logic [7:0]  matrix_length_q, matrix_length_d;
  logic [63:0] vector_q, vector_d;
  logic [7:0]  fifo_value_q, fifo_value_d;
  logic        fifo_push_q, fifo_push_d;
  logic        start_q, start_d;
  logic        frame_error_q, frame_error_d;
  logic [6:0]  nn, limit, count;
  logic        last, cnt_en;
  logic [5:0]  off;
  logic        need_n, need_idle;
  assign nn = {1'b0, matrix_length_q[5:0]} * {1'b0, matrix_length_q[5:0]};
  assign limit = cmd_q == CMD_SIZE ? 7'd1 : cmd_q == CMD_VECTOR ? matrix_length_q[6:0] : nn;
  assign cnt_en = rx_valid && state_q == S_PAYLOAD && !last;
  assign off = {~count[2:0], 3'b000};
  assign need_n = rx_data == 8'(CMD_MATRIX) || rx_data == 8'(CMD_VECTOR);
  assign need_idle = rx_data == 8'(CMD_MATRIX) || rx_data == 8'(CMD_START);

  mxv_payload_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != S_PAYLOAD),
    .en    (cnt_en),
    .limit (limit),
    .count (count),
    .last  (last)
  );

  // frame parser: next-state, shadow and output register values
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    shadow_len_d = shadow_len_q;
    shadow_vec_d = shadow_vec_q;
    matrix_length_d = matrix_length_q;
    vector_d = vector_q;
    fifo_value_d = fifo_value_q;
    fifo_push_d = 1'b0;
    start_d = 1'b0;
    frame_error_d = 1'b0;
    if (rx_valid)
      case (state_q)
        S_IDLE: state_d = rx_data == HDR ? S_CMD : S_IDLE;
        S_CMD:
          if (!is_cmd(rx_data) || (need_n && matrix_length_q == 8'd0) || (need_idle && mxv_busy)) begin
            frame_error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cmd_d = cmd_e'(rx_data[2:0]);
            state_d = rx_data == 8'(CMD_START) ? S_TAIL : S_PAYLOAD;
            if (rx_data == 8'(CMD_VECTOR)) shadow_vec_d = '0;
          end
        S_PAYLOAD: begin
          state_d = last ? S_TAIL : S_PAYLOAD;
          if (cmd_q == CMD_SIZE) begin
            if (rx_data == 8'd0 || rx_data > 8'(MAX_N)) begin
              frame_error_d = 1'b1;
              state_d = S_IDLE;
            end else shadow_len_d = rx_data[3:0];
          end else if (cmd_q == CMD_VECTOR) shadow_vec_d[off +: 8] = rx_data;
          else begin
            fifo_value_d = rx_data;
            fifo_push_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          if (rx_data != TAIL) frame_error_d = 1'b1;
          else if (cmd_q == CMD_SIZE) begin
            matrix_length_d = {4'd0, shadow_len_q};
            vector_d = '0;
          end else if (cmd_q == CMD_VECTOR) vector_d = shadow_vec_q;
          else if (cmd_q == CMD_START) start_d = 1'b1;
        end
      endcase
  end

  // state, shadow and output registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q <= CMD_SIZE;
      shadow_len_q <= 4'd0;
      shadow_vec_q <= '0;
      matrix_length_q <= 8'd0;
      vector_q <= '0;
      fifo_value_q <= 8'd0;
      fifo_push_q <= 1'b0;
      start_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      shadow_len_q <= shadow_len_d;
      shadow_vec_q <= shadow_vec_d;
      matrix_length_q <= matrix_length_d;
      vector_q <= vector_d;
      fifo_value_q <= fifo_value_d;
      fifo_push_q <= fifo_push_d;
      start_q <= start_d;
      frame_error_q <= frame_error_d;
    end

  assign matrix_length = matrix_length_q;
  assign vector = vector_q;
  assign fifo_value = fifo_value_q;
  assign fifo_push = fifo_push_q;
  assign start = start_q;
  assign frame_error = frame_error_q;
endmodule

// File: tb/tb_mxv_frame_loader.sv
// tb_mxv_frame_loader: directed frames with scoreboard of expected push/start/error events
module tb_mxv_frame_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        mxv_busy = 1'b0;
  logic [7:0]  matrix_length;
  logic [63:0] vector;
  logic [7:0]  fifo_value;
  logic        fifo_push;
  logic        start;
  logic        frame_error;
  int          total = 0;
  int          bad = 0;
  logic [9:0]  exp_q[$];
  localparam logic [1:0] K_PUSH = 2'd1, K_START = 2'd2, K_ERR = 2'd3;

  mxv_frame_loader dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .mxv_busy      (mxv_busy),
    .matrix_length (matrix_length),
    .vector        (vector),
    .fifo_value    (fifo_value),
    .fifo_push     (fifo_push),
    .start         (start),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_all(input logic [7:0] bs[$]);
    foreach (bs[i]) begin
      send(bs[i]);
      if (i % 2 == 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [7:0] v);
    exp_q.push_back({k, v});
  endtask

  // monitor: every presented event is checked against the scoreboard head
  always @(negedge clk) begin
    logic [9:0] got, want;
    if (reset && (fifo_push || start || frame_error)) begin
      if (32'(fifo_push) + 32'(start) + 32'(frame_error) > 1) chk("exclusive", {61'd0, fifo_push, start, frame_error}, 64'd0);
      got = fifo_push ? {K_PUSH, fifo_value} : start ? {K_START, 8'd0} : {K_ERR, 8'd0};
      if (exp_q.size() == 0) chk("unexpected_event", 64'(got), 64'd0);
      else begin
        want = exp_q.pop_front();
        chk("event", 64'(got), 64'(want));
      end
    end
  end

  task automatic check_zero(input string name);
    chk({name, "_len"}, 64'(matrix_length), 64'd0);
    chk({name, "_vec"}, vector, 64'd0);
    chk({name, "_strobes"}, {56'd0, fifo_value, 61'd0, fifo_push, start, frame_error} >> 64, 64'd0);
    chk({name, "_fifo_value"}, 64'(fifo_value), 64'd0);
    chk({name, "_pulses"}, {61'd0, fifo_push, start, frame_error}, 64'd0);
  endtask

  initial begin
    #10000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    // VECTOR while unconfigured
    expect_ev(K_ERR, 0);
    send_all('{8'hFE, 8'h04, 8'h11, 8'hEF});
    chk("vec_unconfigured", vector, 64'd0);
    // 1: size 4
    send_all('{8'hFE, 8'h01, 8'h04, 8'hEF});
    chk("size4_len", 64'(matrix_length), 64'd4);
    chk("size4_vec", vector, 64'd0);
    // 2: vector with N=4
    send_all('{8'hFE, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF});
    chk("vec4", vector, 64'h11223344_00000000);
    // new size clears vector
    send_all('{8'hFE, 8'h01, 8'h02, 8'hEF});
    chk("size2_len", 64'(matrix_length), 64'd2);
    chk("size2_clears_vec", vector, 64'd0);
    // 3: matrix N=2 then start
    for (int i = 1; i <= 4; i++) expect_ev(K_PUSH, 8'(i));
    send_all('{8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEF});
    expect_ev(K_START, 0);
    send_all('{8'hFE, 8'h02, 8'hEF});
    // 4: illegal size
    expect_ev(K_ERR, 0);
    send_all('{8'hFE, 8'h01, 8'h09, 8'hEF});
    chk("bad_size_len", 64'(matrix_length), 64'd2);
    expect_ev(K_ERR, 0);
    send_all('{8'hFE, 8'h01, 8'h00, 8'hEF});
    // 5: good vector then bad-tail vector
    send_all('{8'hFE, 8'h04, 8'h55, 8'h66, 8'hEF});
    chk("vec2", vector, 64'h55660000_00000000);
    expect_ev(K_ERR, 0);
    send_all('{8'hFE, 8'h04, 8'hAA, 8'hBB, 8'h00});
    chk("bad_tail_vec", vector, 64'h55660000_00000000);
    // illegal command, header as command
    expect_ev(K_ERR, 0);
    send_all('{8'hFE, 8'hFE});
    expect_ev(K_ERR, 0);
    send_all('{8'hFE, 8'h07});
    // 6: busy refuses START and MATRIX, VECTOR still accepted
    mxv_busy = 1'b1;
    expect_ev(K_ERR, 0);
    send_all('{8'hFE, 8'h02, 8'hEF});
    expect_ev(K_ERR, 0);
    send_all('{8'hFE, 8'h03, 8'h01});
    send_all('{8'hFE, 8'h04, 8'h01, 8'h02, 8'hEF});
    chk("busy_vec", vector, 64'h01020000_00000000);
    mxv_busy = 1'b0;
    // reset mid-matrix
    expect_ev(K_PUSH, 8'h01);
    send_all('{8'hFE, 8'h03, 8'h01});
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    expect_ev(K_ERR, 0);
    send_all('{8'h02, 8'h03, 8'hFE, 8'h03});
    // N=3 vector after recovery
    send_all('{8'hFE, 8'h01, 8'h03, 8'hEF});
    chk("size3_len", 64'(matrix_length), 64'd3);
    send_all('{8'hFE, 8'h04, 8'h01, 8'h02, 8'h03, 8'hEF});
    chk("vec3", vector, 64'h01020300_00000000);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
